// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_fetch
//  Description : Single-stage instruction fetch with PC register, IF/ID
//                pipeline register, branch redirect, stall and halt control.
//  Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
    parameter int N = 32,
    parameter int M = 256
) (
    input  logic         clk,
    input  logic         rst_n,
    output logic [N-1:0] imem_addr,
    input  logic [N-1:0] imem_instr,
    input  logic         stall,
    input  logic         branch_taken,
    input  logic [N-1:0] branch_target,
    input  logic         halt_req,
    output logic [N-1:0] if_id_instr,
    output logic [N-1:0] if_id_pc,
    output logic         if_id_valid,
    output logic         halted
);

    localparam logic [N-1:0] c_DEPTH = N'(M);
    localparam logic [N-1:0] c_LAST  = N'(M - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t       r_state;
    logic [N-1:0] r_pc;
    logic [N-1:0] r_if_instr;
    logic [N-1:0] r_if_pc;
    logic         r_if_valid;
    logic         r_halted;

    logic [N-1:0] w_target;
    logic [N-1:0] w_pc_inc;

    // Branch targets are instruction indices; fold out-of-range values into memory.
    assign w_target = branch_target % c_DEPTH;
    assign w_pc_inc = (r_pc == c_LAST) ? '0 : r_pc + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_pc       <= '0;
            r_if_instr <= '0;
            r_if_pc    <= '0;
            r_if_valid <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    if (branch_taken) begin
                        r_pc       <= w_target;
                        r_if_valid <= 1'b0;
                    end else if (halt_req && !stall) begin
                        r_state    <= S_HALT;
                        r_halted   <= 1'b1;
                        r_if_valid <= 1'b0;
                    end else if (!stall) begin
                        r_if_instr <= imem_instr;
                        r_if_pc    <= r_pc;
                        r_if_valid <= 1'b1;
                        r_pc       <= w_pc_inc;
                    end
                end
                S_HALT: begin
                    r_if_valid <= 1'b0;
                    r_halted   <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign imem_addr   = r_pc;
    assign if_id_instr = r_if_instr;
    assign if_id_pc    = r_if_pc;
    assign if_id_valid = r_if_valid;
    assign halted      = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instruction_fetch
//  Description : Randomized plus directed bench for instruction_fetch,
//                checked against a cycle-level behavioural reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

    localparam int N = 32;
    localparam int M = 256;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] imem_addr;
    logic [N-1:0] imem_instr;
    logic         stall;
    logic         branch_taken;
    logic [N-1:0] branch_target;
    logic         halt_req;
    logic [N-1:0] if_id_instr;
    logic [N-1:0] if_id_pc;
    logic         if_id_valid;
    logic         halted;

    logic [N-1:0] mem [0:M-1];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    bit           m_known  = 0;
    bit           m_idle   = 0;
    bit           m_halted = 0;
    int           m_pc     = 0;
    bit           m_valid  = 0;
    logic [N-1:0] m_instr  = '0;
    logic [N-1:0] m_ifpc   = '0;

    instruction_fetch #(.N(N), .M(M)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_addr    (imem_addr),
        .imem_instr   (imem_instr),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .halt_req     (halt_req),
        .if_id_instr  (if_id_instr),
        .if_id_pc     (if_id_pc),
        .if_id_valid  (if_id_valid),
        .halted       (halted)
    );

    assign imem_instr = (imem_addr < M) ? mem[imem_addr[7:0]] : '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // One clock of the reference: priority reset > branch > halt > stall > advance.
    task automatic model_step();
        if (!rst_n) begin
            m_known = 1; m_idle = 1; m_halted = 0;
            m_pc = 0; m_valid = 0; m_instr = '0; m_ifpc = '0;
        end else if (!m_known || m_halted) begin
            // nothing changes
        end else if (m_idle) begin
            m_idle = 0;
        end else if (branch_taken) begin
            m_pc    = int'(branch_target % M);
            m_valid = 0;
        end else if (halt_req && !stall) begin
            m_halted = 1;
            m_valid  = 0;
        end else if (!stall) begin
            m_instr = mem[m_pc];
            m_ifpc  = N'(m_pc);
            m_valid = 1;
            m_pc    = (m_pc + 1) % M;
        end
    endtask

    task automatic compare_all();
        if (m_known) begin
            check_eq("imem_addr", imem_addr, N'(m_pc));
            check_eq("if_id_valid", N'(if_id_valid), N'(m_valid));
            check_eq("halted", N'(halted), N'(m_halted));
            check_eq("if_id_pc", if_id_pc, m_ifpc);
            check_eq("if_id_instr", if_id_instr, m_instr);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic set_in(input bit r, input bit s, input bit b, input logic [N-1:0] t, input bit h);
        rst_n = r; stall = s; branch_taken = b; branch_target = t; halt_req = h;
    endtask

    initial begin
        for (int i = 0; i < M; i++) mem[i] = $urandom;
        set_in(0, 0, 0, '0, 0);

        // Reset state
        tick(); tick();
        check_eq("rst_addr", imem_addr, 0);
        check_eq("rst_valid", N'(if_id_valid), 0);
        check_eq("rst_halted", N'(halted), 0);
        check_eq("rst_ifpc", if_id_pc, 0);
        check_eq("rst_instr", if_id_instr, 0);

        // Release: one IDLE cycle, then sequential fetch
        set_in(1, 0, 0, '0, 0);
        tick();
        check_eq("idle_valid", N'(if_id_valid), 0);
        check_eq("idle_addr", imem_addr, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("seq_ifpc", if_id_pc, N'(i));
            check_eq("seq_instr", if_id_instr, mem[i]);
            check_eq("seq_valid", N'(if_id_valid), 1);
        end

        // Stall holds IF/ID at pc 2, fetch address at 3
        set_in(1, 1, 0, '0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("stall_ifpc", if_id_pc, 2);
            check_eq("stall_addr", imem_addr, 3);
        end
        set_in(1, 0, 0, '0, 0);
        tick();
        check_eq("resume_ifpc", if_id_pc, 3);
        check_eq("resume_addr", imem_addr, 4);

        // Branch from PC 4 to 6
        set_in(1, 0, 1, 32'd6, 0);
        tick();
        check_eq("br_valid", N'(if_id_valid), 0);
        check_eq("br_addr", imem_addr, 6);
        set_in(1, 0, 0, '0, 0);
        tick();
        check_eq("br_ifpc", if_id_pc, 6);
        check_eq("br_ifvalid", N'(if_id_valid), 1);

        // Branch wins over stall
        set_in(1, 1, 1, 32'd20, 0);
        tick();
        check_eq("brst_addr", imem_addr, 20);
        check_eq("brst_valid", N'(if_id_valid), 0);

        // Out-of-range target folds modulo M
        set_in(1, 0, 1, 32'd300, 0);
        tick();
        check_eq("brmod_addr", imem_addr, 44);

        // Wrap at M-1
        set_in(1, 0, 1, 32'd255, 0);
        tick();
        check_eq("wrap_pre", imem_addr, 255);
        set_in(1, 0, 0, '0, 0);
        tick();
        check_eq("wrap_addr", imem_addr, 0);
        check_eq("wrap_ifpc", if_id_pc, 255);
        check_eq("wrap_valid", N'(if_id_valid), 1);

        // Halt at PC 5, branch ignored, reset exits
        set_in(0, 0, 0, '0, 0);
        tick();
        set_in(1, 0, 0, '0, 0);
        for (int i = 0; i < 6; i++) tick();
        check_eq("pre_halt_addr", imem_addr, 5);
        set_in(1, 1, 0, '0, 1);
        tick();
        check_eq("halt_stall_ign", N'(halted), 0);
        set_in(1, 0, 0, '0, 1);
        tick();
        check_eq("halt_halted", N'(halted), 1);
        check_eq("halt_valid", N'(if_id_valid), 0);
        check_eq("halt_addr", imem_addr, 5);
        set_in(1, 0, 1, 32'd9, 0);
        tick(); tick();
        check_eq("halt_br_addr", imem_addr, 5);
        check_eq("halt_br_halted", N'(halted), 1);
        set_in(0, 0, 0, '0, 0);
        tick();
        check_eq("unhalt_halted", N'(halted), 0);
        check_eq("unhalt_addr", imem_addr, 0);
        check_eq("unhalt_valid", N'(if_id_valid), 0);

        // Randomized phase against the reference model
        for (int c = 0; c < 1500; c++) begin
            rst_n         = !(($urandom_range(0, 99) < 2) || (m_halted && $urandom_range(0, 7) == 0));
            stall         = ($urandom_range(0, 99) < 30);
            branch_taken  = ($urandom_range(0, 99) < 10);
            branch_target = ($urandom_range(0, 1) == 0) ? N'($urandom_range(0, M - 1)) : N'($urandom);
            halt_req      = ($urandom_range(0, 99) < 4);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter N, default 32: word width of the PC, address and instruction.
REQ-002 SHALL have parameter M, default 256: instruction memory depth in words; PC range 0..M-1.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port imem_addr  output  N  word index presented to the instruction memory; equals the PC register.
REQ-006 SHALL have port imem_instr  input  N  instruction word, combinationally returned for imem_addr in the same cycle.
REQ-007 SHALL have port stall  input  1  hazard hold from downstream; freezes the PC and IF/ID.
REQ-008 SHALL have port branch_taken  input  1  redirect request from the execute stage.
REQ-009 SHALL have port branch_target  input  N  redirect destination as an instruction index, not a byte offset.
REQ-010 SHALL have port halt_req  input  1  request to stop fetching.
REQ-011 SHALL have port if_id_instr  output  N  registered fetched instruction.
REQ-012 SHALL have port if_id_pc  output  N  registered PC of if_id_instr.
REQ-013 SHALL have port if_id_valid  output  1  IF/ID holds a real instruction; 0 means bubble.
REQ-014 SHALL have port halted  output  1  fetch unit is in the HALT state.

Function
REQ-015 SHALL implement FSM states IDLE, RUN and HALT.
REQ-016 IDLE SHALL last exactly one cycle after rst_n deasserts, with imem_addr=0 and no IF/ID capture; the next state SHALL be RUN.
REQ-017 In RUN, with stall=0 and branch_taken=0, each edge SHALL load if_id_instr=imem_instr, if_id_pc=PC, if_id_valid=1, and PC=PC+1.
REQ-018 PC increment SHALL wrap modulo M: PC=M-1 SHALL be followed by PC=0.
REQ-019 PC SHALL advance by 1 per instruction, with no byte scaling and no shift.
REQ-020 In RUN, stall=1 with branch_taken=0 SHALL hold the PC, if_id_instr, if_id_pc and if_id_valid unchanged.
REQ-021 In RUN, branch_taken=1 SHALL load PC=branch_target mod M and set if_id_valid=0 (flush) on the same edge; this holds regardless of stall.
REQ-022 After a redirect, the first valid IF/ID entry SHALL carry if_id_pc = target, one cycle after the redirect edge when stall=0.
REQ-023 Priority SHALL be rst_n > branch_taken > halt_req > stall > normal advance.
REQ-024 In RUN, halt_req=1 with branch_taken=0 and stall=0 SHALL move the FSM to HALT and set if_id_valid=0; the PC SHALL hold.
REQ-025 halt_req together with stall SHALL be ignored until stall drops, if halt_req is still asserted then.
REQ-026 In HALT, the PC SHALL stay frozen, if_id_valid SHALL be 0 and halted SHALL be 1; branch_taken, stall and halt_req SHALL be ignored; only reset exits HALT.
REQ-027 imem_addr SHALL be a direct register output, with no combinational path from any input.
REQ-028 if_id_instr and if_id_pc SHALL keep their last values when if_id_valid is 0; no bus zeroing except on reset.

Reset
REQ-029 On a clk edge with rst_n=0: PC=0, if_id_instr=0, if_id_pc=0, if_id_valid=0, halted=0, state=IDLE.
REQ-030 Reset mid-operation, including during stall, branch or HALT, SHALL take effect on the next edge, overriding all other inputs.
REQ-031 Before the first edge with rst_n=0, output values are not specified.

Verification
REQ-032 Bench SHALL cover: memory preloaded at indices 0..7, reset released, no stall -> after IDLE, if_id_pc = 0,1,2,3… on consecutive cycles, with if_id_instr equal to memory at that index.
REQ-033 Bench SHALL cover: stall=1 for 3 cycles while if_id_pc=2 -> if_id_pc stays 2 and imem_addr stays 3 for 3 cycles; resumes with 3.
REQ-034 Bench SHALL cover: branch_taken=1 with branch_target=6 while PC=4 -> next cycle if_id_valid=0 and imem_addr=6; following cycle if_id_pc=6, if_id_valid=1.
REQ-035 Bench SHALL cover: branch_taken=1 with stall=1 together -> branch wins: imem_addr=target and if_id_valid=0.
REQ-036 Bench SHALL cover: PC reaches M-1=255 -> next imem_addr=0 and if_id_pc=255 valid.
REQ-037 Bench SHALL cover: halt_req=1 at PC=5 -> halted=1 and if_id_valid=0 thereafter; a later branch is ignored; rst_n=0 for one edge returns to IDLE with PC=0 and halted=0.
